// File: rtl/tt_check_pkg.sv
// Shared types and constants for the truth-table response checker.
package tt_check_pkg;

    localparam int unsigned SETTLE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // Number of rows in an exhaustive truth table for n_in inputs.
    function automatic int unsigned tbl_depth(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter; terminal_c flags the last count before expiry.
module tt_settle_timer
    import tt_check_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                en,
    input  logic [SETTLE_W-1:0] value,
    output logic                terminal_c
);

    logic [SETTLE_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - SETTLE_W'(1);
        end
    end

    assign terminal_c = (count == SETTLE_W'(1));

endmodule

// File: rtl/tt_resp_checker.sv
// Response-side checker: samples y_in after a settle delay for each applied
// vector and compares it with the expected truth table.
module tt_resp_checker
    import tt_check_pkg::*;
#(
    parameter int unsigned                    N_IN          = 4,
    parameter logic [tbl_depth(N_IN)-1:0]     EXP_TABLE     = '0,
    parameter int unsigned                    SETTLE_CYCLES = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            vec_valid,
    input  logic [N_IN-1:0] vec_in,
    input  logic            y_in,
    output logic            busy,
    output logic            ready,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            proto_err
);

    localparam int unsigned DEPTH = tbl_depth(N_IN);

    state_t            state;
    logic [N_IN-1:0]   vec_q;
    logic [DEPTH-1:0]  seen;
    logic [DEPTH-1:0]  seen_next;
    logic              mismatch;
    logic              timer_load;
    logic              timer_en;
    logic              settle_last_c;

    assign timer_load = (state == ARMED) && vec_valid && !start;
    assign timer_en   = (state == SETTLE);

    tt_settle_timer u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .en         (timer_en),
        .value      (SETTLE_W'(SETTLE_CYCLES)),
        .terminal_c (settle_last_c)
    );

    // Case inequality so an X/Z response is scored as a failure in simulation.
    assign mismatch  = (y_in !== EXP_TABLE[vec_q]);
    assign seen_next = seen | (DEPTH'(1) << vec_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec_q            <= '0;
            seen             <= '0;
            busy             <= 1'b0;
            ready            <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            proto_err        <= 1'b0;
        end else if (start) begin
            // Start wins over everything, including a vector in flight.
            state            <= ARMED;
            seen             <= '0;
            busy             <= 1'b1;
            ready            <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            proto_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                end
                ARMED: begin
                    if (vec_valid) begin
                        vec_q <= vec_in;
                        ready <= 1'b0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (vec_valid) proto_err <= 1'b1;
                    if (settle_last_c) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (vec_valid) proto_err <= 1'b1;
                    if (mismatch) begin
                        if (!(&err_count)) err_count <= err_count + (N_IN+1)'(1);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= vec_q;
                        end
                    end
                    seen <= seen_next;
                    if (&seen_next) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch && !proto_err && !vec_valid;
                    end else begin
                        state <= ARMED;
                        ready <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tt_resp_checker.md
Name: tt_resp_checker

Overview:
- Synthesizable response-side checker for exhaustive truth-table tests of small combinational blocks.
- Sits opposite the stimulus driver. The driver applies an N_IN-bit input vector and pulses vec_valid; this block waits a settle time, samples the DUT output y_in, and compares it against a parameterised expected truth table.
- Accumulates mismatch count, first failing vector and coverage of all 2^N_IN vectors. Reports done/pass for on-board or simulation self-check.

Parameters:
- N_IN, 4: number of DUT inputs; vector width; table depth 2^N_IN.
- EXP_TABLE, 16'h0000: expected output; bit k = expected y for input vector k (MSB of vector = first input, i.e. a). Width 2^N_IN.
- SETTLE_CYCLES, 5: clock cycles between vector acceptance and sampling of y_in; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; clears results and arms the checker.
- vec_valid  in  1  single-cycle pulse; vec_in holds a newly applied vector.
- vec_in  in  N_IN  input vector currently driven onto the DUT.
- y_in  in  1  DUT output under test.
- busy  out  1  high from start until done.
- ready  out  1  high when a new vec_valid will be accepted (state ARMED).
- done  out  1  high once all 2^N_IN distinct vectors have been checked; held until start or reset.
- pass  out  1  valid when done; 1 iff err_count==0 and proto_err==0.
- err_count  out  N_IN+1  number of mismatching samples; saturates at all-ones.
- first_fail_valid  out  1  a mismatch has been recorded.
- first_fail_vec  out  N_IN  vector of the first mismatch.
- proto_err  out  1  sticky: vec_valid seen while not ready during a run.

Behaviour:
- Reset, asynchronous on rst_n low:
  - State IDLE.
  - All outputs 0; seen mask, settle counter and latched vector cleared.
- States:
  - IDLE: busy=0, ready=0. start -> clear err_count, first_fail_*, proto_err, seen mask and done -> ARMED.
  - ARMED: busy=1, ready=1. vec_valid -> latch vec_in, load settle counter with SETTLE_CYCLES -> SETTLE.
  - SETTLE: decrement each cycle; at counter==1 -> SAMPLE. The sample occurs exactly SETTLE_CYCLES+1 cycles after the vec_valid edge.
  - SAMPLE: one cycle.
    - Compare y_in with EXP_TABLE[latched vec].
    - Mismatch: err_count += 1, saturating. If first_fail_valid==0, set first_fail_valid=1 and first_fail_vec=latched vec.
    - Set seen[vec].
    - If the seen mask becomes all-ones -> DONE, else -> ARMED.
  - DONE: busy=0, ready=0, done=1, pass valid. start -> restart as from IDLE.
- Registered outputs only; done/pass assert the cycle after SAMPLE.
- Duplicate vector: compared and counted again; the seen mask is unchanged, so done does not advance.
- vec_valid while busy and not in ARMED (SETTLE/SAMPLE): ignored, proto_err set, sample in flight unaffected.
- vec_valid in IDLE or DONE: ignored, no proto_err.
- start in any state, including mid-SETTLE: aborts the current vector and clears all results; next cycle is ARMED.
- start and vec_valid in the same cycle: start wins, vector discarded.
- rst_n low mid-run: immediate return to reset values; no partial results retained.
- y_in X/Z in simulation is treated as a mismatch (use !== style compare in the reference model).

Decomposition:
- Shared package tt_check_pkg:
  - State encoding typedef {IDLE, ARMED, SETTLE, SAMPLE, DONE}.
  - Constant for the settle counter width (8).
  - Function computing table depth from N_IN.
- One natural sub-module: tt_settle_timer, a loadable down-counter with a terminal flag, reusable by the stimulus driver side.

Test Plan:
1. N_IN=4, EXP_TABLE=16'hA5C3, DUT model correct; start, then 16 vectors 0..15 in order, each held 50 cycles, SETTLE_CYCLES=5 -> done=1, pass=1, err_count=0, first_fail_valid=0, done one cycle after the 16th SAMPLE.
2. Same, but y_in forced inverted for vectors 3 and 9 -> err_count=2, first_fail_vec=4'b0011, pass=0, done=1.
3. Vectors 0..14 plus vector 5 repeated -> done stays 0 and busy stays 1. Then apply vector 15 -> done=1.
4. vec_valid pulsed 2 cycles after a prior vec_valid (mid-SETTLE) -> proto_err=1, first vector still checked, pass=0 at done.
5. start pulsed mid-SETTLE after 2 mismatches -> err_count=0, first_fail_valid=0, ready=1 next cycle; rerun with correct DUT -> pass=1.
6. rst_n driven low for 1 ns asynchronously mid-run -> all outputs 0 immediately; vec_valid after release ignored until start.
